// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the multi-cycle ALU execute stage.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_AW = 3;
  localparam int unsigned ST_W   = 3;

  typedef enum logic [ST_W-1:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4,
    DONE = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    CMP = 2'b01,
    AND = 2'b10,
    MVN = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    LSL1 = 2'b01,
    LSR1 = 2'b10,
    ASR1 = 2'b11
  } shift_t;

  // Instruction register contents latched when a request is accepted.
  typedef struct packed {
    op_t                op;
    shift_t             shift;
    logic [REG_AW-1:0]  rn;
    logic [REG_AW-1:0]  rm;
    logic [REG_AW-1:0]  rd;
  } instr_t;

endpackage

// File: rtl/shift_alu.sv
// Combinational operand-B shifter followed by the ALU and its Z/N/V flag logic.
module shift_alu
  import alu_seq_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  op_t          op,
  input  shift_t       shift,
  output logic [W-1:0] result_c,
  output logic [2:0]   flags_c
);

  logic [W-1:0] bs;
  logic         v;

  always_comb begin
    bs = b;
    case (shift)
      LSL1:    bs = {b[W-2:0], 1'b0};
      LSR1:    bs = {1'b0, b[W-1:1]};
      ASR1:    bs = {b[W-1], b[W-1:1]};
      default: bs = b;
    endcase
  end

  // Overflow only exists for the arithmetic ops; carry out is discarded.
  always_comb begin
    result_c = '0;
    v        = 1'b0;
    case (op)
      ADD: begin
        result_c = a + bs;
        v        = (a[W-1] == bs[W-1]) && (result_c[W-1] != a[W-1]);
      end
      CMP: begin
        result_c = a - bs;
        v        = (a[W-1] != bs[W-1]) && (result_c[W-1] != a[W-1]);
      end
      AND:     result_c = a & bs;
      default: result_c = ~bs;
    endcase
    flags_c = {(result_c == '0), result_c[W-1], v};
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle execute stage: reads two registers, runs shift+ALU, writes back, reports Z/N/V.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [1:0]        shift,
  input  logic [REG_AW-1:0] rn,
  input  logic [REG_AW-1:0] rm,
  input  logic [REG_AW-1:0] rd,
  input  logic [W-1:0]      rf_data,
  output logic [REG_AW-1:0] readnum,
  output logic [REG_AW-1:0] writenum,
  output logic              write,
  output logic [W-1:0]      wb_data,
  output logic [2:0]        status,
  output logic              busy,
  output logic              done
);

  localparam logic [ST_W-1:0] S_IDLE = ST_W'(IDLE);
  localparam logic [ST_W-1:0] S_RD_A = ST_W'(RD_A);
  localparam logic [ST_W-1:0] S_RD_B = ST_W'(RD_B);
  localparam logic [ST_W-1:0] S_EXEC = ST_W'(EXEC);
  localparam logic [ST_W-1:0] S_WB   = ST_W'(WB);
  localparam logic [ST_W-1:0] S_DONE = ST_W'(DONE);

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_next;
  instr_t          ir;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    c_q;
  logic [W-1:0]    alu_result;
  logic [2:0]      alu_flags;

  shift_alu #(.W(W)) u_shift_alu (
    .a        (a_q),
    .b        (b_q),
    .op       (ir.op),
    .shift    (ir.shift),
    .result_c (alu_result),
    .flags_c  (alu_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // CMP only updates flags, so it skips the writeback cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RD_A;
      S_RD_A:  state_next = S_RD_B;
      S_RD_B:  state_next = S_EXEC;
      S_EXEC:  state_next = (ir.op == CMP) ? S_DONE : S_WB;
      S_WB:    state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath registers and registered register-file controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      status  <= '0;
      readnum <= '0;
      write   <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        ir <= '{op: op_t'(op), shift: shift_t'(shift), rn: rn, rm: rm, rd: rd};
      end
      if (state == S_RD_A) a_q <= rf_data;
      if (state == S_RD_B) b_q <= rf_data;
      if (state == S_EXEC) begin
        c_q    <= alu_result;
        status <= alu_flags;
      end
      // RD_A is only ever entered from IDLE, so rn comes straight from the request.
      readnum <= (state_next == S_RD_A) ? rn : ir.rm;
      write   <= (state_next == S_WB);
      done    <= (state_next == S_DONE);
      busy    <= (state_next != S_IDLE);
    end
  end

  assign writenum = ir.rd;
  assign wb_data  = c_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural register file and an expectation queue.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int unsigned W = DATA_W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [1:0]   shift;
  logic [2:0]   rn, rm, rd;
  logic [W-1:0] rf_data;
  logic [2:0]   readnum, writenum;
  logic         write;
  logic [W-1:0] wb_data;
  logic [2:0]   status;
  logic         busy, done;

  logic [W-1:0] regs [8];

  typedef struct {
    logic [2:0]   rd;
    logic [W-1:0] data;
    logic [2:0]   st;
    logic         cmp;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  alu_sequencer #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .shift    (shift),
    .rn       (rn),
    .rm       (rm),
    .rd       (rd),
    .rf_data  (rf_data),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .wb_data  (wb_data),
    .status   (status),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Register file: combinational read, write at the rising edge.
  assign rf_data = regs[readnum];
  always @(posedge clk) if (write) regs[writenum] = wb_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [1:0] s, input logic [2:0] d,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [W-1:0] bs, r;
    int           sa, sbv, full;
    logic         v;
    case (s)
      2'd1:    bs = b << 1;
      2'd2:    bs = b >> 1;
      2'd3:    bs = W'($signed(b) >>> 1);
      default: bs = b;
    endcase
    sa   = int'($signed(a));
    sbv  = int'($signed(bs));
    full = 0;
    v    = 1'b0;
    case (o)
      2'd0: begin full = sa + sbv; r = W'(full); v = (full > 32767) || (full < -32768); end
      2'd1: begin full = sa - sbv; r = W'(full); v = (full > 32767) || (full < -32768); end
      2'd2:    r = a & bs;
      default: r = ~bs;
    endcase
    e.rd   = d;
    e.data = r;
    e.st   = {(r == '0), r[W-1], v};
    e.cmp  = (o == 2'd1);
    return e;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [1:0] s,
                       input logic [2:0] a_n, input logic [2:0] b_n, input logic [2:0] d);
    sb.push_back(model(o, s, d, regs[a_n], regs[b_n]));
    op = o; shift = s; rn = a_n; rm = b_n; rd = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Follows one instruction from cycle 1 to DONE; optionally pulses start while busy.
  task automatic finish_check(input string tag, input bit pulse);
    exp_t e;
    int   nwr, wcyc, dcyc;
    e    = sb.pop_front();
    nwr  = 0;
    wcyc = 0;
    dcyc = 0;
    for (int cyc = 1; cyc <= 10 && dcyc == 0; cyc++) begin
      start = pulse && (cyc < 5);
      if (write) begin
        nwr++;
        wcyc = cyc;
        chk({tag, " writenum"}, 32'(writenum), 32'(e.rd));
        chk({tag, " wb_data"}, 32'(wb_data), 32'(e.data));
      end
      if (done) dcyc = cyc;
      else tick();
    end
    start = 1'b0;
    chk({tag, " status"}, 32'(status), 32'(e.st));
    chk({tag, " writes"}, 32'(nwr), e.cmp ? 32'd0 : 32'd1);
    if (!e.cmp) chk({tag, " write cycle"}, 32'(wcyc), 32'd4);
    chk({tag, " done cycle"}, 32'(dcyc), e.cmp ? 32'd4 : 32'd5);
    tick();
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nwr;
    int dq [$];

    for (int i = 0; i < 8; i++) regs[i] = '0;
    rst_n = 1'b0; start = 1'b0; op = '0; shift = '0; rn = '0; rm = '0; rd = '0;
    tick();
    tick();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst write", 32'(write), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst readnum", 32'(readnum), 32'd0);
    chk("rst writenum", 32'(writenum), 32'd0);
    chk("rst wb_data", 32'(wb_data), 32'd0);
    chk("rst status", 32'(status), 32'd0);
    rst_n = 1'b1;

    // Plain ADD
    regs[1] = 16'd5; regs[2] = 16'd3;
    issue(ADD, NONE, 3'd1, 3'd2, 3'd3);
    finish_check("add", 1'b0);
    chk("add r3", 32'(regs[3]), 32'd8);

    // CMP equal operands, with start pulses while busy
    regs[1] = 16'd5; regs[2] = 16'd5;
    issue(CMP, NONE, 3'd1, 3'd2, 3'd7);
    finish_check("cmp", 1'b1);
    chk("cmp flags", 32'(status), 32'b100);
    chk("cmp r7 kept", 32'(regs[7]), 32'd0);

    // Signed overflow to zero
    regs[4] = 16'h8000; regs[5] = 16'h8000;
    issue(ADD, NONE, 3'd4, 3'd5, 3'd6);
    finish_check("ovf", 1'b0);
    chk("ovf r6", 32'(regs[6]), 32'd0);
    chk("ovf flags", 32'(status), 32'b101);

    // MVN with arithmetic shift
    regs[2] = 16'h8004;
    issue(MVN, ASR1, 3'd1, 3'd2, 3'd0);
    finish_check("mvn", 1'b0);
    chk("mvn r0", 32'(regs[0]), 32'h3FFD);

    // AND with left shift, destination aliases rn
    regs[1] = 16'h00F0; regs[2] = 16'h0F0F;
    issue(AND, LSL1, 3'd1, 3'd2, 3'd1);
    finish_check("and", 1'b1);
    chk("and r1", 32'(regs[1]), 32'h0010);

    // Full aliasing rn==rm==rd with logical right shift
    regs[5] = 16'h4000;
    issue(ADD, LSR1, 3'd5, 3'd5, 3'd5);
    finish_check("alias", 1'b0);
    chk("alias r5", 32'(regs[5]), 32'h6000);

    // start held high: back-to-back instructions every 6 cycles
    regs[1] = 16'd5; regs[2] = 16'd3; regs[3] = 16'd0;
    op = ADD; shift = NONE; rn = 3'd1; rm = 3'd2; rd = 3'd3;
    start = 1'b1;
    nwr = 0;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (write) nwr++;
      if (done) dq.push_back(c);
    end
    start = 1'b0;
    chk("hold writes", 32'(nwr), 32'd3);
    chk("hold dones", 32'(dq.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      chk("hold done cycle", (k < dq.size()) ? 32'(dq[k]) : 32'hFFFF_FFFF, 32'(6 * k + 5));
    tick();
    chk("hold r3", 32'(regs[3]), 32'd8);
    chk("hold idle", 32'(busy), 32'd0);

    // Reset asserted during WB
    regs[4] = 16'd10; regs[5] = 16'd20; regs[6] = 16'h1234;
    issue(ADD, NONE, 3'd4, 3'd5, 3'd6);
    tick(); tick(); tick();
    chk("wb write", 32'(write), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstwb write", 32'(write), 32'd0);
    chk("rstwb busy", 32'(busy), 32'd0);
    chk("rstwb done", 32'(done), 32'd0);
    chk("rstwb readnum", 32'(readnum), 32'd0);
    chk("rstwb writenum", 32'(writenum), 32'd0);
    chk("rstwb wb_data", 32'(wb_data), 32'd0);
    chk("rstwb status", 32'(status), 32'd0);
    void'(sb.pop_front());
    tick();
    chk("rstwb r6 kept", 32'(regs[6]), 32'h1234);
    rst_n = 1'b1;

    issue(ADD, NONE, 3'd4, 3'd5, 3'd6);
    finish_check("post rst", 1'b0);
    chk("post rst r6", 32'(regs[6]), 32'd30);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle execute stage sitting directly downstream of the 8×16-bit register file. On a start request it:
- reads two source registers through the register file's combinational read port;
- captures them into A/B operand registers;
- shifts B and performs the ALU operation;
- writes the result back through the register file's write port.

It drives the register file's `readnum`, `writenum` and `write` inputs and consumes its `data_out`. It also produces Z/N/V status for the branch logic.

## Interface
- Parameter `W`, default 16: datapath width; must match the register file width.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request; sampled only in IDLE.
- `op`, input, 2: 00 ADD, 01 CMP, 10 AND, 11 MVN.
- `shift`, input, 2: applied to B. 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1 (sign fill).
- `rn`, input, 3: source A register number.
- `rm`, input, 3: source B register number.
- `rd`, input, 3: destination register number.
- `rf_data`, input, W: register file `data_out`.
- `readnum`, output, 3: to register file.
- `writenum`, output, 3: to register file.
- `write`, output, 1: to register file write enable.
- `wb_data`, output, W: to register file `data_in`; always equals C.
- `status`, output, 3: {Z, N, V}.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle completion pulse.

## Operation
- States: IDLE, RD_A, RD_B, EXEC, WB, DONE.
- IDLE, `start`=1:
  - latch `op`, `shift`, `rn`, `rm`, `rd` into an instruction register;
  - go to RD_A.
  - Inputs are ignored at all other times; `start` while busy is dropped, not queued.
- RD_A: `readnum`=latched rn; A <= `rf_data` at the edge; go to RD_B.
- RD_B: `readnum`=latched rm; B <= `rf_data` at the edge; go to EXEC.
- EXEC: compute Bs = shift(B), then:
  - ADD: A+Bs.
  - CMP: A−Bs.
  - AND: A&Bs.
  - MVN: ~Bs (A ignored).
  - C <= result and status <= flags of the result at the edge.
  - Next state is WB, except CMP, which goes straight to DONE.
- Flags:
  - Z = (result==0).
  - N = result[W-1].
  - V = two's-complement signed overflow for ADD/CMP, 0 for AND/MVN.
- Arithmetic is modulo 2^W; carry is discarded.
- WB: `write`=1, `writenum`=latched rd, `wb_data`=C; go to DONE. CMP never asserts `write`.
- DONE: `done`=1; go to IDLE. A new `start` is accepted on the cycle after DONE.
- Register aliasing:
  - rn==rm and rd==rn/rm are legal; reads complete before writeback.
  - With `op`=CMP, `rd` is don't-care.
- When not in RD_A/RD_B, `readnum` holds the latched rm. It is stable, not X.

## Timing
- Cycle 0: IDLE samples `start`=1.
- Cycles 1–5: RD_A, RD_B, EXEC, WB, DONE.
- `write` is high in cycle 4 only; the register file updates at the end of cycle 4.
- `done` is high in cycle 5.
- CMP: DONE in cycle 4; `write` never high.
- Throughput: one instruction per 6 cycles (5 for CMP), including the IDLE cycle.
- `rf_data` must be valid combinationally within the same cycle `readnum` is driven. The register file read path is a pure mux, so no extra wait state.
- Reset values (asserted asynchronously, at any time, including mid-operation): state IDLE; A, B, C, instruction register, `status` all 0; `write`, `done`, `busy` 0; `readnum`, `writenum` 0.
  - An interrupted instruction is abandoned.
  - A WB cycle cut by reset produces no write, because `write` drops asynchronously.
  - Register file contents are not reset by this block.
- Release of `rst_n` is synchronised externally; the first `start` is honoured on the first edge after release.

## Structure
- Package `alu_seq_pkg`:
  - `state_t` enum (IDLE..DONE);
  - `op_t` (ADD, CMP, AND, MVN) and `shift_t` (NONE, LSL1, LSR1, ASR1) enums;
  - the `W` default constant.
- One sub-module: `shift_alu`, purely combinational. Inputs A, B, op, shift; outputs result and {Z, N, V}. The sequencer instantiates it once and registers its outputs in EXEC.
- All flops use async active-low reset; no latches.

## Test plan
- Preload R1=5, R2=3; ADD rd=3, rn=1, rm=2, shift=00 -> `write` in cycle 4 with `writenum`=3, `wb_data`=8; `done` in cycle 5; status=000.
- R1=5, R2=5; CMP rn=1, rm=2 -> status Z=1, N=0, V=0; `write` never asserted; `done` in cycle 4.
- R4=16'h8000, R5=16'h8000; ADD rd=6 -> R6=0; status Z=1, V=1.
- R2=16'h8004; MVN rd=0, rm=2, shift=ASR1 -> Bs=16'hC002; R0=16'h3FFD; N=0.
- Hold `start`=1 continuously -> instructions complete back-to-back every 6 cycles; `start` pulses during `busy` produce no extra writes.
- Assert `rst_n`=0 during WB -> `write` drops immediately; destination register unchanged; all outputs 0; next `start` runs normally.
